// File: rtl/seg7_pkg.sv
// Shared definitions for the 3-bit seven-segment display path (encoders and scan reader).
// On the pins every segment line and digit select is active-low (0 = lit / selected).
package seg7_pkg;

  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  // Lit-segment patterns {a,b,c,d,e,f,g}, 1 = lit; the pins carry the inverse.
  localparam logic [6:0] SEG_PAT [0:7] = '{
    7'b1111110,  // 0
    7'b0110000,  // 1
    7'b1101101,  // 2
    7'b1111001,  // 3
    7'b0110011,  // 4
    7'b1011011,  // 5
    7'b1011111,  // 6
    7'b1110000   // 7
  };

  typedef enum logic {
    ST_TRACK = 1'b0,
    ST_HOLD  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg7_pat_decode.sv
// Combinational match of a 7-bit lit-segment pattern against the eight 3-bit glyphs.
module seg7_pat_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pat,
  output logic       ok,
  output logic [2:0] val
);

  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
    ok  = 1'b0;
    val = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pat == SEG_PAT[i]) begin
        ok  = 1'b1;
        val = 3'(i);
      end
    end
  end

endmodule

// File: rtl/seg7_scan_rx.sv
// Scan reader for the multiplexed 7-segment bus: synchronize, stability-filter, decode,
// and keep a per-digit register file with one-cycle update / error strobes.
module seg7_scan_rx
  import seg7_pkg::*;
#(
  parameter int NDIG          = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        seg_in,
  input  logic [NDIG-1:0]   sel_in,
  output logic [3*NDIG-1:0] digit_val,
  output logic [NDIG-1:0]   digit_ok,
  output logic              upd,
  output logic [2:0]        upd_idx,
  output logic              err
);

  localparam int             CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES);

  logic [7:0]        seg_s1_q, seg_s2_q, seg_prev_q;
  logic [NDIG-1:0]   sel_s1_q, sel_s2_q, sel_prev_q;
  scan_state_e       state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3*NDIG-1:0] val_q, val_d;
  logic [NDIG-1:0]   ok_q, ok_d;
  logic              upd_q, upd_d;
  logic              err_q, err_d;
  logic [2:0]        idx_q, idx_d;

  logic              dec_ok;
  logic [2:0]        dec_val;
  logic              changed, commit, sel_valid;
  logic [NDIG-1:0]   sel_low;
  int                sel_idx;

  // The prev stage holds the value being counted, so a commit always uses the stable word.
  seg7_pat_decode u_dec (
    .pat (~seg_prev_q[7:1]),
    .ok  (dec_ok),
    .val (dec_val)
  );

  always_comb begin
    changed   = {seg_s2_q, sel_s2_q} != {seg_prev_q, sel_prev_q};
    commit    = (state_q == ST_TRACK) && (cnt_q == CNT_MAX);
    sel_low   = ~sel_prev_q;
    sel_valid = (sel_low != '0) && ((sel_low & (sel_low - NDIG'(1))) == '0);
    sel_idx   = 0;
    for (int i = 0; i < NDIG; i++) begin
      if (sel_low[i]) sel_idx = i;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    ok_d    = ok_q;
    idx_d   = idx_q;
    upd_d   = 1'b0;
    err_d   = 1'b0;

    if (commit) begin
      state_d = ST_HOLD;
      if (sel_valid) begin
        val_d[3*sel_idx +: 3] = dec_ok ? dec_val : 3'd0;
        ok_d[sel_idx]         = dec_ok;
        idx_d                 = 3'(sel_idx);
        upd_d                 = 1'b1;
        err_d                 = ~dec_ok;
      end
    end

    // A change restarts tracking even on a commit edge; the commit above still lands.
    if (changed) begin
      state_d = ST_TRACK;
      cnt_d   = CW'(1);
    end else if (state_q == ST_TRACK && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q   <= '1;
      seg_s2_q   <= '1;
      seg_prev_q <= '1;
      sel_s1_q   <= '1;
      sel_s2_q   <= '1;
      sel_prev_q <= '1;
      state_q    <= ST_TRACK;
      cnt_q      <= '0;
      val_q      <= '0;
      ok_q       <= '0;
      upd_q      <= 1'b0;
      err_q      <= 1'b0;
      idx_q      <= 3'd0;
    end else begin
      seg_s1_q   <= seg_in;
      seg_s2_q   <= seg_s1_q;
      seg_prev_q <= seg_s2_q;
      sel_s1_q   <= sel_in;
      sel_s2_q   <= sel_s1_q;
      sel_prev_q <= sel_s2_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      val_q      <= val_d;
      ok_q       <= ok_d;
      upd_q      <= upd_d;
      err_q      <= err_d;
      idx_q      <= idx_d;
    end
  end

  assign digit_val = val_q;
  assign digit_ok  = ok_q;
  assign upd       = upd_q;
  assign upd_idx   = idx_q;
  assign err       = err_q;

endmodule
